// File: rtl/ros_freq_meter_if.sv
// Request/result bundle of the ring-oscillator frequency meter.
// The meter is the slave; the readout logic is the master.
interface ros_freq_meter_if #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
);
  logic              start;
  logic [GATE_W-1:0] gate_cycles;
  logic [CNT_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;
  logic              busy;
  logic              overflow;

  modport master (
    output start, gate_cycles, result_ready,
    input  result, result_valid, busy, overflow
  );

  modport slave (
    input  start, gate_cycles, result_ready,
    output result, result_valid, busy, overflow
  );
endinterface

// File: rtl/ros_freq_meter.sv
// Counts synchronised rising edges of a prescaled ring-oscillator output over a
// window of gate_cycles clk cycles and returns the count by valid/ready.
//
// state | meaning
// IDLE  | waiting for start; result/overflow hold the previous measurement
// GATE  | window open, rises are counted, win_q counts down to 1
// DONE  | result_valid high, waiting for result_ready
module ros_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ros_in,
  ros_freq_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               prev_q;
  logic               rise;
  logic [GATE_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]   edge_q, edge_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ovf_q, ovf_d;
  logic               ovf_inc;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               valid_q, valid_d;

  // ros_in is asynchronous; the chain runs in every state so its history is
  // already settled when a window opens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ros_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= '0;
      edge_q   <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      edge_q   <= edge_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    edge_d   = edge_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    valid_d  = valid_q;
    cnt_inc  = edge_q;
    ovf_inc  = ovf_q;

    // Saturating count: a rise at full scale only flags overflow.
    if (rise) begin
      if (edge_q == CNT_MAX) ovf_inc = 1'b1;
      else                   cnt_inc = edge_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          win_d    = bus.gate_cycles;
          edge_d   = '0;
          ovf_d    = 1'b0;
          result_d = '0;
          if (bus.gate_cycles == '0) begin
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = GATE;
          end
        end
      end
      GATE: begin
        win_d  = win_q - GATE_W'(1);
        edge_d = cnt_inc;
        ovf_d  = ovf_inc;
        if (win_q == GATE_W'(1)) begin
          result_d = cnt_inc;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (valid_q && bus.result_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.overflow     = ovf_q;
  assign bus.busy         = (state_q != IDLE);

endmodule
